// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage for an RV32I core. Takes one load or store per request
// from the execute stage, validates width code and alignment, drives a simple
// request/acknowledge memory bus and returns the sign/zero-extended load result.
//
// Handshake: in IDLE a request is taken on any rising edge where start=1.
// On the bus, mem_req is held high together with stable mem_addr/mem_be/
// mem_wdata/mem_we until the first edge that sees mem_ack=1; that edge
// completes the transfer and mem_req drops on the following cycle. mem_ack
// while mem_req=0 and start while busy=1 are ignored.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              op request from execute (sampled only in IDLE)
//   is_store           1 = store, 0 = load
//   funct3             RV32I width/sign code
//   addr               effective byte address
//   wdata              store data (rs2)
//   busy               pipeline stall, high whenever the FSM is not IDLE
//   done               one-cycle pulse when an op completes on the bus
//   rdata              extended load result, held until the next load
//   misaligned         one-cycle pulse for a misaligned access
//   fault              one-cycle pulse for illegal funct3 or bus timeout
//   mem_req, mem_we    bus request / write strobe
//   mem_addr           word-aligned bus address
//   mem_wdata          store data replicated across byte lanes
//   mem_be             byte enables
//   mem_ack            bus accept
//   mem_rdata          bus read data, valid with mem_ack
//   dbg_state_o        current FSM state, for observation only
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1: the REQ cycle holding
  // that value without an ack is the last one allowed.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [2:0]     funct3_q, funct3_d;
  logic           is_store_q, is_store_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    rdata_q, rdata_d;
  // Distinguishes the two ERR causes: 1 = fault, 0 = misaligned.
  logic           err_fault_q, err_fault_d;

  // Decode of the incoming request (only meaningful while IDLE).
  logic           op_legal;
  logic           op_misal;
  logic [3:0]     op_be;
  logic [31:0]    op_wdata;

  // Load result from the bus data of the acknowledging cycle.
  logic [31:0]    lane;
  logic [31:0]    load_ext;

  always_comb begin
    op_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: op_legal = 1'b1;
      3'b100, 3'b101:         op_legal = !is_store;
      default:                op_legal = 1'b0;
    endcase

    // funct3[1:0] is the access size: 00 byte, 01 half, 10 word.
    op_misal = 1'b0;
    op_be    = 4'b1111;
    op_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        op_be    = 4'b0001 << addr[1:0];
        op_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        op_misal = addr[0];
        op_be    = 4'b0011 << {addr[1], 1'b0};
        op_wdata = {2{wdata[15:0]}};
      end
      default: begin
        op_misal = (addr[1:0] != 2'b00);
        op_be    = 4'b1111;
        op_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    lane     = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rdata_d     = rdata_q;
    err_fault_d = err_fault_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Illegal width code wins over misalignment.
          if (!op_legal) begin
            state_d     = S_ERR;
            err_fault_d = 1'b1;
          end else if (op_misal) begin
            state_d     = S_ERR;
            err_fault_d = 1'b0;
          end else begin
            state_d    = S_REQ;
            cnt_d      = '0;
            addr_d     = addr;
            funct3_d   = funct3;
            is_store_d = is_store;
            wdata_d    = op_wdata;
            be_d       = op_be;
          end
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          state_d = S_RESP;
          if (!is_store_q) begin
            rdata_d = load_ext;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_ERR;
          err_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      err_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      err_fault_q <= err_fault_d;
    end
  end

  // All outputs decode the registered state; bus fields are gated to zero
  // outside REQ so an idle bus carries no stale values.
  logic in_req;
  assign in_req      = (state_q == S_REQ);

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_RESP);
  assign misaligned  = (state_q == S_ERR) && !err_fault_q;
  assign fault       = (state_q == S_ERR) && err_fault_q;
  assign rdata       = rdata_q;
  assign mem_req     = in_req;
  assign mem_we      = in_req && is_store_q;
  assign mem_addr    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata   = in_req ? wdata_q : 32'h0;
  assign mem_be      = in_req ? be_q : 4'h0;
  assign dbg_state_o = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles mem_req waits for mem_ack before a fault.
REQ-002 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  memory op request from execute stage; sampled only in IDLE.
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code.
REQ-008 addr  input  32  effective address (ALU Result).
REQ-009 wdata  input  32  store data (rs2).
REQ-010 busy  output  1  pipeline stall; high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse on op completion.
REQ-012 rdata  output  32  extended load result; valid while done=1, held until next done.
REQ-013 misaligned  output  1  one-cycle pulse on misaligned access.
REQ-014 fault  output  1  one-cycle pulse on illegal funct3 or bus timeout.
REQ-015 mem_req, mem_we  output  1 each  bus request / write strobe.
REQ-016 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_be  output  4  byte enables.
REQ-019 mem_ack  input  1  bus accept; mem_rdata  input  32  read data, valid with mem_ack.

Function
REQ-020 SHALL implement FSM IDLE, REQ, RESP, ERR.
REQ-021 IDLE + start: illegal funct3 -> ERR, fault=1 next cycle; misaligned -> ERR, misaligned=1 next cycle; else latch addr/funct3/is_store/wdata -> REQ.
REQ-022 Legal: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all else illegal.
REQ-023 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; byte never; illegal check takes priority.
REQ-024 ERR lasts one cycle, returns to IDLE, issues no bus request.
REQ-025 REQ: mem_req=1, mem_we=is_store; mem_addr/mem_be/mem_wdata stable from latched values until ack.
REQ-026 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; loads drive same mask.
REQ-027 mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-028 REQ + mem_ack -> RESP; mem_req deasserts next cycle; ack on first REQ cycle legal.
REQ-029 RESP: done=1 one cycle, -> IDLE; loads update rdata, stores leave rdata unchanged.
REQ-030 Load extract: lane = mem_rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW as-is; captured on ack cycle.
REQ-031 Latency: start at cycle 0 -> mem_req cycle 1; ack at cycle k -> done at k+1; zero-wait total 3 cycles start-to-done.
REQ-032 Timeout counter clears on entering REQ, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES -> ERR with fault=1, mem_req dropped, no done.
REQ-033 mem_ack outside REQ, and start outside IDLE, SHALL be ignored.
REQ-034 busy SHALL be registered state decode, never combinational from start.

Reset
REQ-035 reset SHALL force IDLE, counter 0, and all outputs (busy, done, rdata, misaligned, fault, mem_*) to 0 at the next edge.
REQ-036 Reset during REQ SHALL drop mem_req next edge without done or fault; later ack ignored.

Verification
REQ-037 LB addr=0x1003, mem_rdata=0x80FF_0000 ack zero-wait -> mem_be=1000, rdata=0xFFFFFF80, done 3 cycles after start.
REQ-038 SH addr=0x2002, wdata=0x0000ABCD, ack after 4 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, done once, rdata unchanged.
REQ-039 LW addr=0x3001 -> misaligned pulse 1 cycle, mem_req never high, busy 1 cycle; funct3=011 -> fault pulse.
REQ-040 LHU addr=0x4000, no ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then fault pulse, no done, IDLE.
REQ-041 Reset asserted in REQ, ack next cycle -> all outputs 0, no done; new LBU addr=0x0001, mem_rdata=0x0000_9A00 -> rdata=0x0000009A.
